// File: rtl/rl_pair_scheduler_if.sv
// Handshake/bus bundle between the pair scheduler, the particle memories and the filter bank.
// Optional perf counters appear when PAIR_SCHED_PERF_CNT_EN is defined.
interface rl_pair_scheduler_if #(
  parameter int NUM_FILTER        = 7,
  parameter int PARTICLE_ID_WIDTH = 7
);
  localparam int NF = NUM_FILTER;
  localparam int W  = PARTICLE_ID_WIDTH;

  logic            start;
  logic [W-1:0]    num_ref;
  logic [NF*W-1:0] num_nb;
  logic [NF-1:0]   back_pressure;
  logic            all_buffer_empty;
  logic [W-1:0]    ref_particle_id;
  logic [W-1:0]    nb_rd_addr;
  logic [W-1:0]    nb_particle_id;
  logic [NF-1:0]   pair_valid;
  logic            busy;
  logic            done;

`ifdef PAIR_SCHED_PERF_CNT_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     drain_cycles;

  modport master (
    output start, num_ref, num_nb,
    output back_pressure, all_buffer_empty,
    input  ref_particle_id, nb_rd_addr,
    input  nb_particle_id, pair_valid,
    input  busy, done,
    input  stall_cycles, drain_cycles
  );

  modport slave (
    input  start, num_ref, num_nb,
    input  back_pressure, all_buffer_empty,
    output ref_particle_id, nb_rd_addr,
    output nb_particle_id, pair_valid,
    output busy, done,
    output stall_cycles, drain_cycles
  );
`else
  modport master (
    output start, num_ref, num_nb,
    output back_pressure, all_buffer_empty,
    input  ref_particle_id, nb_rd_addr,
    input  nb_particle_id, pair_valid,
    input  busy, done
  );

  modport slave (
    input  start, num_ref, num_nb,
    input  back_pressure, all_buffer_empty,
    output ref_particle_id, nb_rd_addr,
    output nb_particle_id, pair_valid,
    output busy, done
  );
`endif
endinterface

// File: rtl/rl_pair_scheduler.sv
// Pair-generation FSM for one home cell: walks ref x neighbor slots over all filter lanes.
// Define PAIR_SCHED_PERF_CNT_EN to add stall/drain cycle counters.
module rl_pair_scheduler #(
  parameter int NUM_FILTER        = 7,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int RD_LATENCY        = 1,
  parameter int DRAIN_WAIT        = 2
) (
  input logic               clk,
  input logic               rst,
  rl_pair_scheduler_if.slave bus
);

  localparam int NF = NUM_FILTER;
  localparam int W  = PARTICLE_ID_WIDTH;
  localparam int CW = (DRAIN_WAIT < 2) ? 1
                    : $clog2(DRAIN_WAIT + 1);
  localparam logic [W-1:0]  ONE_W  = 1;
  localparam logic [CW-1:0] ONE_C  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_NEXT_REF,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [W-1:0]           num_ref_q;
  logic [NF-1:0][W-1:0]   num_nb_q;
  logic [W-1:0]           ref_cnt_q;
  logic [W-1:0]           nb_cnt_q;
  logic [W-1:0]           nb_rd_addr_q;
  logic [NF-1:0]          iss_q;
  logic [CW-1:0]          drain_cnt_q;
  logic                   busy_q;
  logic                   done_q;

  logic [RD_LATENCY-1:0][NF-1:0] vld_pipe_q;
  logic [RD_LATENCY-1:0][W-1:0]  addr_pipe_q;

  logic [NF-1:0][W-1:0]   num_nb_in;
  logic [W-1:0]           nb_max;
  logic [NF-1:0]          issue_mask;
  logic                   nb_any_in;
  logic                   any_bp;
  logic                   last_slot;
  logic                   pipe_busy;
  logic                   drain_hit;

  assign num_nb_in = bus.num_nb;
  assign any_bp    = |bus.back_pressure;
  assign last_slot = (nb_cnt_q == nb_max - ONE_W);
  assign pipe_busy = (|iss_q) | (|vld_pipe_q);
  assign drain_hit = (int'(drain_cnt_q) + 1 >= DRAIN_WAIT);

  always_comb begin
    nb_max = '0;
    for (int i = 0; i < NF; i++) begin
      if (num_nb_q[i] > nb_max) nb_max = num_nb_q[i];
    end
  end

  always_comb begin
    issue_mask = '0;
    for (int i = 0; i < NF; i++) begin
      issue_mask[i] = (nb_cnt_q < num_nb_q[i]);
    end
  end

  always_comb begin
    nb_any_in = 1'b0;
    for (int i = 0; i < NF; i++) begin
      nb_any_in = nb_any_in | (|num_nb_in[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_ref_q    <= '0;
      num_nb_q     <= '0;
      ref_cnt_q    <= '0;
      nb_cnt_q     <= '0;
      nb_rd_addr_q <= '0;
      iss_q        <= '0;
      drain_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      iss_q  <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            num_ref_q   <= bus.num_ref;
            num_nb_q    <= num_nb_in;
            ref_cnt_q   <= '0;
            nb_cnt_q    <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b1;
            if (bus.num_ref == '0 || !nb_any_in)
              state_q <= S_DONE;
            else
              state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // a stalled cycle holds address and count; the pipe still drains
          if (!any_bp) begin
            nb_rd_addr_q <= nb_cnt_q;
            iss_q        <= issue_mask;
            nb_cnt_q     <= nb_cnt_q + ONE_W;
            if (last_slot) begin
              drain_cnt_q <= '0;
              state_q     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!pipe_busy && bus.all_buffer_empty) begin
            if (drain_hit)
              state_q <= S_NEXT_REF;
            else
              drain_cnt_q <= drain_cnt_q + ONE_C;
          end else begin
            drain_cnt_q <= '0;
          end
        end
        S_NEXT_REF: begin
          ref_cnt_q   <= ref_cnt_q + ONE_W;
          nb_cnt_q    <= '0;
          drain_cnt_q <= '0;
          if (ref_cnt_q == num_ref_q - ONE_W)
            state_q <= S_DONE;
          else
            state_q <= S_ISSUE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // read-latency alignment of valids and neighbor index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
    end else begin
      vld_pipe_q[0]  <= iss_q;
      addr_pipe_q[0] <= nb_rd_addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign bus.ref_particle_id = ref_cnt_q;
  assign bus.nb_rd_addr      = nb_rd_addr_q;
  assign bus.nb_particle_id  = addr_pipe_q[RD_LATENCY-1];
  assign bus.pair_valid      = vld_pipe_q[RD_LATENCY-1];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

`ifdef PAIR_SCHED_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] drain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      drain_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      stall_q <= '0;
      drain_q <= '0;
    end else begin
      if (state_q == S_ISSUE && any_bp && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (state_q == S_DRAIN && drain_q != 32'hFFFF_FFFF)
        drain_q <= drain_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.drain_cycles = drain_q;
`endif

endmodule

// File: tb/tb_rl_pair_scheduler.sv
// Directed bench for rl_pair_scheduler: hand-computed beat lists and cycle-exact checks.
module tb_rl_pair_scheduler;

  localparam int NF = 7;
  localparam int W  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   done_cnt = 0;

  logic [NF-1:0] bv[$];
  int            bid[$];
  int            bref[$];
  int            bcyc[$];

  rl_pair_scheduler_if #(.NUM_FILTER(NF), .PARTICLE_ID_WIDTH(W)) bus ();

  rl_pair_scheduler #(
    .NUM_FILTER(NF), .PARTICLE_ID_WIDTH(W),
    .RD_LATENCY(1), .DRAIN_WAIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (|bus.pair_valid) begin
      bv.push_back(bus.pair_valid);
      bid.push_back(int'(bus.nb_particle_id));
      bref.push_back(int'(bus.ref_particle_id));
      bcyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int nr, input int nbv[7]);
    bus.num_ref = W'(nr);
    for (int i = 0; i < NF; i++) bus.num_nb[i*W +: W] = W'(nbv[i]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int n = 0;
    while (done_cnt == base && n < 2000) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, " done pulses"}, 32'(done_cnt - base), 32'd1);
    chk({tag, " busy idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_uniform(input string tag, input int b0,
                             input int nref, input int nnb);
    chk({tag, " beats"}, 32'(bv.size() - b0), 32'(nref * nnb));
    for (int k = 0; k < nref * nnb && b0 + k < bv.size(); k++) begin
      chk({tag, " pv"}, 32'(bv[b0+k]), 32'h7F);
      chk({tag, " nb"}, 32'(bid[b0+k]), 32'(k % nnb));
      chk({tag, " ref"}, 32'(bref[b0+k]), 32'(k / nnb));
    end
  endtask

  initial begin
    int b0, d0, n;
    int pat[3];
    bus.start = 1'b0;
    bus.back_pressure = '0;
    bus.all_buffer_empty = 1'b1;
    cfg(0, '{0,0,0,0,0,0,0});

    #1;
    chk("rst pv", 32'(bus.pair_valid), 32'd0);
    chk("rst ref", 32'(bus.ref_particle_id), 32'd0);
    chk("rst addr", 32'(bus.nb_rd_addr), 32'd0);
    chk("rst nbid", 32'(bus.nb_particle_id), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // two refs, all lanes 3 slots
    cfg(2, '{3,3,3,3,3,3,3});
    b0 = bv.size(); d0 = done_cnt;
    pulse_start();
    wait_done("basic", d0);
    chk_uniform("basic", b0, 2, 3);

    // uneven lanes
    cfg(1, '{1,2,3,0,0,0,0});
    b0 = bv.size(); d0 = done_cnt;
    pulse_start();
    wait_done("uneven", d0);
    chk("uneven beats", 32'(bv.size() - b0), 32'd3);
    pat = '{7'h07, 7'h06, 7'h04};
    for (int k = 0; k < 3 && b0 + k < bv.size(); k++) begin
      chk("uneven pv", 32'(bv[b0+k]), 32'(pat[k]));
      chk("uneven nb", 32'(bid[b0+k]), 32'(k));
    end

    // back_pressure on lane 2 for 5 cycles mid-issue
    cfg(1, '{8,8,8,8,8,8,8});
    b0 = bv.size(); d0 = done_cnt;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 bus.back_pressure = 7'h04;
    repeat (5) @(posedge clk);
    #1 bus.back_pressure = '0;
    wait_done("bp", d0);
    chk_uniform("bp", b0, 1, 8);
    if (bv.size() - b0 == 8)
      chk("bp gap", 32'(bcyc[b0+7] - bcyc[b0] + 1 - 8), 32'd5);

    // drain hold-off with all_buffer_empty low
    cfg(2, '{2,2,2,2,2,2,2});
    bus.all_buffer_empty = 1'b0;
    b0 = bv.size(); d0 = done_cnt;
    pulse_start();
    n = 0;
    while (bv.size() - b0 < 2 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("drain first beats", 32'(bv.size() - b0 >= 2), 32'd1);
    repeat (10) @(posedge clk);
    #1 chk("drain hold ref", 32'(bus.ref_particle_id), 32'd0);
    bus.all_buffer_empty = 1'b1;
    @(negedge clk);
    chk("drain t0 ref", 32'(bus.ref_particle_id), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("drain t1 ref", 32'(bus.ref_particle_id), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("drain t2 ref", 32'(bus.ref_particle_id), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("drain t3 ref", 32'(bus.ref_particle_id), 32'd1);
    wait_done("drain", d0);
    chk_uniform("drain", b0, 2, 2);

    // empty home cell
    cfg(0, '{3,3,3,3,3,3,3});
    b0 = bv.size(); d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    chk("nref0 done e0", 32'(bus.done), 32'd0);
    chk("nref0 busy e0", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("nref0 done e1", 32'(bus.done), 32'd1);
    chk("nref0 busy e1", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("nref0 pulses", 32'(done_cnt - d0), 32'd1);
    chk("nref0 beats", 32'(bv.size() - b0), 32'd0);

    // async reset in the middle of ISSUE
    cfg(1, '{10,10,10,10,10,10,10});
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (bus.nb_rd_addr != W'(5) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("mid addr5", 32'(bus.nb_rd_addr), 32'd5);
    #1 rst = 1'b1;
    #1;
    chk("mid pv", 32'(bus.pair_valid), 32'd0);
    chk("mid addr", 32'(bus.nb_rd_addr), 32'd0);
    chk("mid nbid", 32'(bus.nb_particle_id), 32'd0);
    chk("mid busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid no done", 32'(done_cnt - d0), 32'd0);
    cfg(2, '{3,3,3,3,3,3,3});
    b0 = bv.size(); d0 = done_cnt;
    pulse_start();
    wait_done("after rst", d0);
    chk_uniform("after rst", b0, 2, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
